// File: rtl/cla_multiword_seq.sv
// Multi-precision add/subtract sequencer: WORDS x 16-bit operands are pushed
// one slice per clock, low slice first, through a single shared 16-bit CLA,
// with the CLA carry-out fed back to its carry-in through a register.

// 16-bit carry-look-ahead adder: four 4-bit groups, look-ahead across groups.
module carry_look_ahead_16bit (
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic        cin,
   output logic [15:0] sum_c,
   output logic        cout_c
);

   logic [15:0] p;
   logic [15:0] g;
   logic [3:0]  gp;
   logic [3:0]  gg;
   logic [4:0]  gc;
   logic        cc;

   // Bit/group generate-propagate, group carries, then in-group sum bits
   always_comb begin
      p     = a ^ b;
      g     = a & b;
      gp    = '0;
      gg    = '0;
      gc    = '0;
      sum_c = '0;
      cc    = 1'b0;

      for (int k = 0; k < 4; k++) begin
         gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
         gg[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      end

      gc[0] = cin;
      gc[1] = gg[0] | (gp[0] & cin);
      gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
      gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
            | (gp[2] & gp[1] & gp[0] & cin);
      gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
            | (gp[3] & gp[2] & gp[1] & gg[0])
            | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

      for (int k = 0; k < 4; k++) begin
         cc = gc[k];
         for (int j = 0; j < 4; j++) begin
            sum_c[4*k+j] = p[4*k+j] ^ cc;
            cc           = g[4*k+j] | (p[4*k+j] & cc);
         end
      end

      cout_c = gc[4];
   end

endmodule

module cla_multiword_seq #(
   parameter int unsigned WORDS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                op_sub,
   input  logic [16*WORDS-1:0] a,
   input  logic [16*WORDS-1:0] b,
   input  logic                cin,
   output logic                busy,
   output logic                done,
   output logic [16*WORDS-1:0] sum,
   output logic                cout,
   output logic                ovf
);

   localparam int unsigned W  = 16 * WORDS;
   localparam int unsigned IW = $clog2(WORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic          busy_d;
   logic          done_d;

   logic [W-1:0]  a_lat;
   logic [W-1:0]  b_eff;
   logic [IW-1:0] idx_q;
   logic          carry_q;

   logic [15:0]   cla_a;
   logic [15:0]   cla_b;
   logic [15:0]   cla_s;
   logic          cla_co;

   // Current slice of the latched operands feeds the shared adder
   always_comb begin
      cla_a = a_lat[{idx_q, 4'd0} +: 16];
      cla_b = b_eff[{idx_q, 4'd0} +: 16];
   end

   carry_look_ahead_16bit u_cla (
      .a      (cla_a),
      .b      (cla_b),
      .cin    (carry_q),
      .sum_c  (cla_s),
      .cout_c (cla_co)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; start is only honoured in IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (idx_q == LAST_IDX) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Status outputs derived from the upcoming state so they register cleanly
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      if (state_d != IDLE) busy_d = 1'b1;
      if (state_d == DONE) done_d = 1'b1;
   end

   // Registered status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
      end
   end

   // Operand capture, per-slice accumulation and final flag update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_lat   <= '0;
         b_eff   <= '0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_lat   <= a;
                  b_eff   <= op_sub ? ~b : b;
                  carry_q <= op_sub ? 1'b1 : cin;
                  idx_q   <= '0;
                  cout    <= 1'b0;
                  ovf     <= 1'b0;
               end
            end
            RUN: begin
               sum[{idx_q, 4'd0} +: 16] <= cla_s;
               carry_q                  <= cla_co;
               if (idx_q == LAST_IDX) begin
                  cout <= cla_co;
                  ovf  <= (a_lat[W-1] == b_eff[W-1]) && (cla_s[15] != a_lat[W-1]);
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
